// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums fixed-length batches of COUNT unsigned products received over a
// valid/ready handshake. Each completed batch is presented on an output
// valid/ready handshake as a registered sum with a sticky overflow flag.
// This is the accumulate half of a multiply-accumulate datapath.
//
// Optional build macro: PRODUCT_ACCUMULATOR_SATURATE_EN
//   undefined : the accumulator wraps modulo 2^ACC_W on overflow
//   defined   : the accumulator saturates at 2^ACC_W - 1 on overflow
//   The overflow flag and the handshake timing are the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort of the current batch or held result
//   in_valid   in   in_product is valid this cycle
//   in_ready   out  block can accept a product (ACCUM state)
//   in_product in   [PROD_W-1:0] unsigned product
//   out_valid  out  out_sum/out_ovf hold a completed batch (HOLD state)
//   out_ready  in   downstream accepts the batch
//   out_sum    out  [ACC_W-1:0] unsigned batch sum
//   out_ovf    out  batch sum exceeded 2^ACC_W - 1 at some point
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic [ACC_W-1:0]   sum_r;
    logic [ACC_W-1:0]   sum_nxt_s;
    logic               sum_ovf_r;
    logic               sum_ovf_nxt_s;

    logic               accept_s;
    logic [ACC_W:0]     sum_ext_s;
    logic [ACC_W-1:0]   acc_add_s;
    logic               ovf_add_s;
    logic               last_s;

    // Resolve the ACC_W+1-bit sum into the stored accumulator value: the
    // carry bit either wraps away or pins the accumulator at full scale.
    function automatic logic [ACC_W-1:0] resolve_acc(input logic [ACC_W:0] s);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        if (s[ACC_W]) begin
            resolve_acc = {ACC_W{1'b1}};
        end else begin
            resolve_acc = s[ACC_W-1:0];
        end
`else
        resolve_acc = s[ACC_W-1:0];
`endif
    endfunction

    // Handshake flags are decoded from the state register alone, so they are
    // glitch-free and mutually exclusive.
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);
    assign out_sum   = sum_r;
    assign out_ovf   = sum_ovf_r;

    assign accept_s  = in_valid & in_ready;
    assign sum_ext_s = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign acc_add_s = resolve_acc(sum_ext_s);
    assign ovf_add_s = ovf_r | sum_ext_s[ACC_W];
    assign last_s    = (cnt_r == CNT_W'(COUNT - 1));

    // Next-state and datapath update; clear overrides both handshakes.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        ovf_nxt_s     = ovf_r;
        sum_nxt_s     = sum_r;
        sum_ovf_nxt_s = sum_ovf_r;

        if (clear) begin
            // The held result registers survive an abort; only the batch
            // state and the valid flag are dropped.
            state_nxt_s = ACCUM;
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (last_s) begin
                            sum_nxt_s     = acc_add_s;
                            sum_ovf_nxt_s = ovf_add_s;
                            acc_nxt_s     = {ACC_W{1'b0}};
                            cnt_nxt_s     = {CNT_W{1'b0}};
                            ovf_nxt_s     = 1'b0;
                            state_nxt_s   = HOLD;
                        end else begin
                            acc_nxt_s = acc_add_s;
                            ovf_nxt_s = ovf_add_s;
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                HOLD: begin
                    // Nothing is accepted in the handoff cycle because
                    // in_ready only rises once the state is back in ACCUM.
                    if (out_ready) begin
                        state_nxt_s = ACCUM;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ACCUM;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ACCUM;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            sum_r     <= {ACC_W{1'b0}};
            sum_ovf_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            ovf_r     <= ovf_nxt_s;
            sum_r     <= sum_nxt_s;
            sum_ovf_r <= sum_ovf_nxt_s;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed self-checking bench for product_accumulator. Two instances share
// the same stimulus: one with default parameters and one with ACC_W = 9 to
// exercise the overflow path. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        out_ovf;

    logic        in_ready9;
    logic        out_valid9;
    logic [8:0]  out_sum9;
    logic        out_ovf9;

    int n_checks;
    int n_errors;

    product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf)
    );

    product_accumulator #(.ACC_W(9)) dut9 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready9),
        .in_product (in_product),
        .out_valid  (out_valid9),
        .out_ready  (out_ready),
        .out_sum    (out_sum9),
        .out_ovf    (out_ovf9)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one product for one cycle; the caller guarantees in_ready.
    task automatic send(input logic [7:0] p);
        in_valid   = 1'b1;
        in_product = p;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle; checks values while asserted.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check_eq({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = 8'd0;
        out_ready  = 1'b1;

        // Reset values.
        #12;
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum",   32'(out_sum),   32'd0);
        check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back batch: 36+12+35+49 = 132, out_valid for one cycle.
        send(8'd36);
        send(8'd12);
        send(8'd35);
        check_eq("b2b_valid_early", 32'(out_valid), 32'd0);
        send(8'd49);
        check_eq("b2b_valid",    32'(out_valid), 32'd1);
        check_eq("b2b_in_ready", 32'(in_ready),  32'd0);
        check_eq("b2b_sum",      32'(out_sum),   32'd132);
        check_eq("b2b_ovf",      32'(out_ovf),   32'd0);
        idle(1);
        check_eq("b2b_valid_drop", 32'(out_valid), 32'd0);
        check_eq("b2b_ready_back", 32'(in_ready),  32'd1);

        // Same products with 3-cycle gaps.
        send(8'd36);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check_eq("gap_in_ready", 32'(in_ready), 32'd1);
        end
        send(8'd12);
        idle(3);
        check_eq("gap_in_ready2", 32'(in_ready), 32'd1);
        send(8'd35);
        idle(3);
        check_eq("gap_valid_low", 32'(out_valid), 32'd0);
        send(8'd49);
        check_eq("gap_valid", 32'(out_valid), 32'd1);
        check_eq("gap_sum",   32'(out_sum),   32'd132);
        idle(1);

        // Backpressure: 25+25+49+21 = 120 held for 5 cycles, inputs ignored.
        out_ready = 1'b0;
        send(8'd25);
        send(8'd25);
        send(8'd49);
        send(8'd21);
        in_valid   = 1'b1;
        in_product = 8'd200;
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_valid",    32'(out_valid), 32'd1);
            check_eq("hold_sum",      32'(out_sum),   32'd120);
            check_eq("hold_in_ready", 32'(in_ready),  32'd0);
            if (k < 4) begin
                idle(1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check_eq("hold_release_valid", 32'(out_valid), 32'd0);
        check_eq("hold_release_ready", 32'(in_ready),  32'd1);
        send(8'd1);
        send(8'd1);
        send(8'd1);
        check_eq("ones_valid_early", 32'(out_valid), 32'd0);
        send(8'd1);
        check_eq("ones_valid", 32'(out_valid), 32'd1);
        check_eq("ones_sum",   32'(out_sum),   32'd4);
        idle(1);

        // Overflow: 4 x 255 = 1020 in 12 bits; in 9 bits wraps to 508 or saturates at 511.
        send(8'd255);
        send(8'd255);
        send(8'd255);
        send(8'd255);
        check_eq("ovf12_sum",   32'(out_sum),    32'd1020);
        check_eq("ovf12_ovf",   32'(out_ovf),    32'd0);
        check_eq("ovf9_valid",  32'(out_valid9), 32'd1);
        check_eq("ovf9_ovf",    32'(out_ovf9),   32'd1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        check_eq("ovf9_sum",    32'(out_sum9),   32'd511);
`else
        check_eq("ovf9_sum",    32'(out_sum9),   32'd508);
`endif
        idle(1);

        // clear after two accepts drops the concurrent product 99.
        send(8'd36);
        send(8'd12);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd99;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_in_ready",  32'(in_ready),  32'd1);
        check_eq("clr_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        send(8'd2);
        send(8'd3);
        send(8'd4);
        check_eq("clr_valid_early", 32'(out_valid), 32'd0);
        send(8'd5);
        check_eq("clr_valid", 32'(out_valid), 32'd1);
        check_eq("clr_sum",   32'(out_sum),   32'd14);

        // clear during HOLD discards the batch but keeps out_sum.
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_eq("clr_hold_valid", 32'(out_valid), 32'd0);
        check_eq("clr_hold_sum",   32'(out_sum),   32'd14);
        out_ready = 1'b1;

        // Asynchronous reset after three accepts.
        send(8'd36);
        send(8'd12);
        send(8'd35);
        mid_reset("rst_mid");

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        send(8'd36);
        send(8'd12);
        send(8'd35);
        send(8'd49);
        check_eq("pre_rst_hold_valid", 32'(out_valid), 32'd1);
        mid_reset("rst_hold");
        out_ready = 1'b1;

        // Fresh batch after resets.
        send(8'd36);
        send(8'd12);
        send(8'd35);
        check_eq("post_rst_valid_early", 32'(out_valid), 32'd0);
        send(8'd49);
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_sum",   32'(out_sum),   32'd132);
        check_eq("post_rst_ovf",   32'(out_ovf),   32'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
